// File: rtl/regfile_scoreboard.sv
// Parametrised integer register file with a per-register busy scoreboard.
// Optional write-through forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2,
  localparam int AW   = $clog2(NREGS),
  localparam int CW   = $clog2(NREGS + 1)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NREAD*AW-1:0]   ra,
  output logic [NREAD*XLEN-1:0] rd,
  output logic [NREAD-1:0]      rbusy,
  input  logic                  we,
  input  logic [AW-1:0]         wa,
  input  logic [XLEN-1:0]       wd,
  input  logic                  rsv_en,
  input  logic [AW-1:0]         rsv_addr,
  output logic                  rsv_waw,
  output logic [CW-1:0]         pending,
  output logic                  idle
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;
  logic [CW-1:0]    pending_next;
  logic             wr_hit;
  logic             set_hit;
  logic             clr_hit;

  assign wr_hit  = we && (wa != '0);
  assign set_hit = rsv_en && (rsv_addr != '0);
  // A reservation landing on the register being written keeps it busy.
  assign clr_hit = wr_hit && !(set_hit && (rsv_addr == wa));

  assign rsv_waw = set_hit && busy[rsv_addr];
  assign idle    = (pending == '0);

  always_comb begin
    busy_next    = busy;
    pending_next = pending;
    if (clr_hit) busy_next[wa] = 1'b0;
    if (set_hit) busy_next[rsv_addr] = 1'b1;
    if (set_hit && !busy[rsv_addr]) pending_next = pending_next + CW'(1);
    if (clr_hit && busy[wa])        pending_next = pending_next - CW'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
      busy    <= '0;
      pending <= '0;
    end else begin
      if (wr_hit) regs[wa] <= wd;
      busy    <= busy_next;
      pending <= pending_next;
    end
  end

  always_comb begin
    rd    = '0;
    rbusy = '0;
    for (int i = 0; i < NREAD; i++) begin
      if (ra[i*AW +: AW] != '0) begin
        rd[i*XLEN +: XLEN] = regs[ra[i*AW +: AW]];
        rbusy[i]           = busy[ra[i*AW +: AW]];
      end
`ifdef REGFILE_BYPASS_EN
      // Forward the writeback value so issue need not wait for the edge.
      if (wr_hit && (wa == ra[i*AW +: AW])) begin
        rd[i*XLEN +: XLEN] = wd;
        rbusy[i]           = set_hit && (rsv_addr == wa);
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed scoreboard bench for regfile_scoreboard: default build plus a
// 64-bit / 16-register / 3-port instance for the parameter sweep.
module tb_regfile_scoreboard;

  localparam int AW  = 5;
  localparam int CW  = 6;
  localparam int WA  = 4;
  localparam int WC  = 5;

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;

  logic [2*AW-1:0] ra = '0;
  logic [63:0]     rd;
  logic [1:0]      rbusy;
  logic            we = 1'b0;
  logic [AW-1:0]   wa = '0;
  logic [31:0]     wd = '0;
  logic            rsv_en = 1'b0;
  logic [AW-1:0]   rsv_addr = '0;
  logic            rsv_waw;
  logic [CW-1:0]   pending;
  logic            idle;

  logic [3*WA-1:0] w_ra = '0;
  logic [191:0]    w_rd;
  logic [2:0]      w_rbusy;
  logic            w_we = 1'b0;
  logic [WA-1:0]   w_wa = '0;
  logic [63:0]     w_wd = '0;
  logic            w_rsv_en = 1'b0;
  logic [WA-1:0]   w_rsv_addr = '0;
  logic            w_rsv_waw;
  logic [WC-1:0]   w_pending;
  logic            w_idle;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  logic [63:0] m64 [16];

  regfile_scoreboard dut (
    .clock(clock), .reset_n(reset_n), .ra(ra), .rd(rd), .rbusy(rbusy),
    .we(we), .wa(wa), .wd(wd), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rsv_waw(rsv_waw), .pending(pending), .idle(idle)
  );

  regfile_scoreboard #(.XLEN(64), .NREGS(16), .NREAD(3)) dut64 (
    .clock(clock), .reset_n(reset_n), .ra(w_ra), .rd(w_rd), .rbusy(w_rbusy),
    .we(w_we), .wa(w_wa), .wd(w_wd), .rsv_en(w_rsv_en), .rsv_addr(w_rsv_addr),
    .rsv_waw(w_rsv_waw), .pending(w_pending), .idle(w_idle)
  );

  always #5 clock = ~clock;

  task automatic expect_val(input logic [63:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs);
    logic [63:0] e;
    checks++;
    assert (exp_q.size() != 0) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=<none queued>", tag, obs);
      return;
    end
    e = exp_q.pop_front();
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
    end
  endtask

  task automatic check_now(input string tag, input logic [63:0] obs, input logic [63:0] e);
    expect_val(e);
    check_output(tag, obs);
  endtask

  task automatic apply_stimulus(input logic w_en, input logic [AW-1:0] w_addr,
                                input logic [31:0] w_data, input logic r_en,
                                input logic [AW-1:0] r_addr);
    we = w_en;
    wa = w_addr;
    wd = w_data;
    rsv_en = r_en;
    rsv_addr = r_addr;
    #1;
  endtask

  // Inputs change 1 time unit after the edge; everything idles afterwards.
  task automatic tick();
    @(posedge clock);
    #1;
    we = 1'b0;
    rsv_en = 1'b0;
    w_we = 1'b0;
    w_rsv_en = 1'b0;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m64[i] = '0;
    $display("[TB] start");
    #1 reset_n = 1'b0;
    #1;
    check_now("reset_rd", rd, 64'h0);
    check_now("reset_rbusy", {62'h0, rbusy}, 64'h0);
    check_now("reset_pending", {58'h0, pending}, 64'h0);
    check_now("reset_idle", {63'h0, idle}, 64'h1);
    check_now("reset_waw", {63'h0, rsv_waw}, 64'h0);
    #10 reset_n = 1'b1;

    // Reset in the middle of operation, between edges.
    tick();
    apply_stimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd7);
    tick();
    ra = {5'd7, 5'd5};
    #1;
    check_now("mid_rd5", {32'h0, rd[31:0]}, 64'hDEADBEEF);
    check_now("mid_rbusy", {62'h0, rbusy}, 64'h2);
    check_now("mid_pending", {58'h0, pending}, 64'h1);
    #1 reset_n = 1'b0;
    #1;
    check_now("async_rd", rd, 64'h0);
    check_now("async_rbusy", {62'h0, rbusy}, 64'h0);
    check_now("async_pending", {58'h0, pending}, 64'h0);
    check_now("async_idle", {63'h0, idle}, 64'h1);
    #1 reset_n = 1'b1;

    // Register 0 ignores writes and reservations.
    ra = '0;
    apply_stimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0);
    check_now("x0_waw", {63'h0, rsv_waw}, 64'h0);
    tick();
    check_now("x0_rd", rd, 64'h0);
    check_now("x0_rbusy", {62'h0, rbusy}, 64'h0);
    check_now("x0_pending", {58'h0, pending}, 64'h0);

    // Scoreboard lifecycle.
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3);
    tick();
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4);
    tick();
    ra = {5'd4, 5'd3};
    #1;
    check_now("life_pending2", {58'h0, pending}, 64'h2);
    check_now("life_idle0", {63'h0, idle}, 64'h0);
    check_now("life_rbusy11", {62'h0, rbusy}, 64'h3);
    expect_val(64'h1);
    apply_stimulus(1'b1, 5'd3, 32'h11, 1'b0, 5'd0);
    tick();
    check_output("life_pending1", {58'h0, pending});
    check_now("life_rbusy10", {62'h0, rbusy}, 64'h2);
    expect_val(64'h0);
    apply_stimulus(1'b1, 5'd4, 32'h22, 1'b0, 5'd0);
    tick();
    check_output("life_pending0", {58'h0, pending});
    check_now("life_idle1", {63'h0, idle}, 64'h1);
    ra = {5'd3, 5'd3};
    #1;
    check_now("life_rd33", rd, {32'h11, 32'h11});
    ra = {5'd4, 5'd4};
    #1;
    check_now("life_rd44", rd, {32'h22, 32'h22});

    // Set and clear on the same address: set wins, data still lands.
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
    tick();
    check_now("col_pending_pre", {58'h0, pending}, 64'h1);
    apply_stimulus(1'b1, 5'd9, 32'h55, 1'b1, 5'd9);
    check_now("col_waw", {63'h0, rsv_waw}, 64'h1);
    tick();
    ra = {5'd0, 5'd9};
    #1;
    check_now("col_rd", {32'h0, rd[31:0]}, 64'h55);
    check_now("col_rbusy", {62'h0, rbusy}, 64'h1);
    check_now("col_pending", {58'h0, pending}, 64'h1);
    apply_stimulus(1'b1, 5'd9, 32'h56, 1'b0, 5'd0);
    tick();
    check_now("col_clear_pending", {58'h0, pending}, 64'h0);
    check_now("col_clear_rd", {32'h0, rd[31:0]}, 64'h56);

    // Set and clear on different addresses both take effect.
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd13);
    tick();
    apply_stimulus(1'b1, 5'd13, 32'h1313, 1'b1, 5'd14);
    tick();
    ra = {5'd14, 5'd13};
    #1;
    check_now("diff_rbusy", {62'h0, rbusy}, 64'h2);
    check_now("diff_pending", {58'h0, pending}, 64'h1);
    check_now("diff_rd", {32'h0, rd[31:0]}, 64'h1313);
    apply_stimulus(1'b1, 5'd14, 32'h1414, 1'b0, 5'd0);
    tick();
    check_now("diff_pending0", {58'h0, pending}, 64'h0);

    // Write-through forwarding (or its absence).
    apply_stimulus(1'b1, 5'd12, 32'h1234, 1'b0, 5'd0);
    tick();
    ra = {5'd0, 5'd12};
    #1;
    check_now("nb_write_rd", {32'h0, rd[31:0]}, 64'h1234);
    check_now("nb_write_pending", {58'h0, pending}, 64'h0);
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd12);
    tick();
    check_now("byp_rbusy_pre", {62'h0, rbusy}, 64'h1);
    apply_stimulus(1'b1, 5'd12, 32'hCAFE0001, 1'b0, 5'd0);
`ifdef REGFILE_BYPASS_EN
    check_now("byp_rd_early", {32'h0, rd[31:0]}, 64'hCAFE0001);
    check_now("byp_rbusy_early", {62'h0, rbusy}, 64'h0);
`else
    check_now("byp_rd_early", {32'h0, rd[31:0]}, 64'h1234);
    check_now("byp_rbusy_early", {62'h0, rbusy}, 64'h1);
`endif
    tick();
    check_now("byp_rd_after", {32'h0, rd[31:0]}, 64'hCAFE0001);
    check_now("byp_rbusy_after", {62'h0, rbusy}, 64'h0);
    check_now("byp_pending", {58'h0, pending}, 64'h0);
    apply_stimulus(1'b1, 5'd12, 32'hCAFE0002, 1'b1, 5'd12);
`ifdef REGFILE_BYPASS_EN
    check_now("bypr_rd_early", {32'h0, rd[31:0]}, 64'hCAFE0002);
    check_now("bypr_rbusy_early", {62'h0, rbusy}, 64'h1);
`else
    check_now("bypr_rd_early", {32'h0, rd[31:0]}, 64'hCAFE0001);
    check_now("bypr_rbusy_early", {62'h0, rbusy}, 64'h0);
`endif
    tick();
    check_now("bypr_rd_after", {32'h0, rd[31:0]}, 64'hCAFE0002);
    check_now("bypr_rbusy_after", {62'h0, rbusy}, 64'h1);
    check_now("bypr_pending", {58'h0, pending}, 64'h1);

    // Wide configuration: fill the scoreboard, then drain it.
    for (int i = 1; i < 16; i++) begin
      w_rsv_en = 1'b1;
      w_rsv_addr = i[3:0];
      tick();
    end
    check_now("sw_pending_full", {59'h0, w_pending}, 64'd15);
    check_now("sw_idle_full", {63'h0, w_idle}, 64'h0);
    w_ra = {4'd3, 4'd2, 4'd0};
    #1;
    check_now("sw_rbusy", {61'h0, w_rbusy}, 64'h6);
    w_rsv_en = 1'b1;
    w_rsv_addr = 4'd5;
    #1;
    check_now("sw_rerserve_waw", {63'h0, w_rsv_waw}, 64'h1);
    tick();
    check_now("sw_rereserve_pending", {59'h0, w_pending}, 64'd15);
    for (int i = 1; i < 16; i++) begin
      m64[i] = {16'hA5A5, 16'(i), 16'h5A5A, 16'(i * 3)};
      expect_val(64'(15 - i));
      w_we = 1'b1;
      w_wa = i[3:0];
      w_wd = m64[i];
      tick();
      check_output("sw_pending_drain", {59'h0, w_pending});
    end
    check_now("sw_idle_empty", {63'h0, w_idle}, 64'h1);
    for (int i = 0; i < 16; i++) begin
      int p1;
      int p2;
      p1 = (i % 15) + 1;
      p2 = (i + 7) % 16;
      w_ra = {p2[3:0], p1[3:0], i[3:0]};
      expect_val(m64[i]);
      expect_val(m64[p1]);
      expect_val(m64[p2]);
      #1;
      check_output("sw_rd_port0", w_rd[63:0]);
      check_output("sw_rd_port1", w_rd[127:64]);
      check_output("sw_rd_port2", w_rd[191:128]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
